// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO.
//   i_Clock      system clock
//   i_Reset_n    asynchronous active-low reset
//   i_Tx_DV      write strobe; a byte is accepted when i_Tx_DV && o_Tx_Ready
//   i_Tx_Byte    byte to queue, sampled only on an accepting edge
//   o_Tx_Ready   FIFO not full
//   o_Tx_Serial  registered serial line, idle high
//   o_Tx_Active  high while a frame (start..stop) is on the line
//   o_Tx_Done    one-cycle pulse after each stop bit completes
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          serial_q, serial_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          push, pop;

    assign o_Tx_Ready  = (count_q != DEPTH_C);
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = done_q;
        pop       = 1'b0;
        // Acceptance depends only on the registered count, so a write while
        // full is refused even if the transmitter pops on the same edge.
        push      = i_Tx_DV && (count_q != DEPTH_C);

        case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                if (count_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    serial_d  = 1'b0;
                    active_d  = 1'b1;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (clk_cnt_q != CNT_LAST) begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end else begin
                    // Shift register always presents the next data bit in [0].
                    clk_cnt_d = '0;
                    serial_d  = shift_q[0];
                    shift_d   = shift_q >> 1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (clk_cnt_q != CNT_LAST) begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end else begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        serial_d  = 1'b1;
                        state_d   = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            S_STOP: begin
                if (clk_cnt_q != CNT_LAST) begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end else begin
                    clk_cnt_d = '0;
                    active_d  = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_CLEANUP;
                end
            end
            S_CLEANUP: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                serial_d  = 1'b1;
                active_d  = 1'b0;
                done_d    = 1'b0;
                clk_cnt_d = '0;
                bit_idx_d = '0;
                state_d   = S_IDLE;
            end
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = i_Tx_Byte;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge i_Clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
//   Instance A (8 clocks/bit) is checked cycle by cycle against a frame-timing
//   model; instance B (434 clocks/bit) is checked by a UART receiver model.
module tb_uart_tx_fifo;

    localparam int N     = 8;
    localparam int NB    = 434;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * N;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv, dv_b;
    logic [7:0] byte_in, byte_b;
    logic       ready, serial, active, done;
    logic       ready_b, serial_b, active_b, done_b;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(N), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv), .i_Tx_Byte(byte_in),
        .o_Tx_Ready(ready), .o_Tx_Serial(serial), .o_Tx_Active(active), .o_Tx_Done(done)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(NB), .FIFO_DEPTH(DEPTH)) dut_b (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv_b), .i_Tx_Byte(byte_b),
        .o_Tx_Ready(ready_b), .o_Tx_Serial(serial_b), .o_Tx_Active(active_b), .o_Tx_Done(done_b)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model for instance A ----------------
    typedef struct {
        logic [7:0] b;
        int         start;
    } frame_t;

    logic [7:0] mfifo[$];
    frame_t     expq[$];
    int         next_pop = 0;
    bit         exp_ready = 1'b1;
    bit         acc;

    // A frame starts on the first edge with data queued once the previous
    // frame plus its two mark cycles has elapsed.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            mfifo.delete();
            expq.delete();
            next_pop  = 0;
            exp_ready = 1'b1;
        end else begin
            acc = dv && (mfifo.size() < DEPTH);
            if (cyc >= next_pop && mfifo.size() > 0) begin
                expq.push_back('{mfifo.pop_front(), cyc});
                next_pop = cyc + FRAME + 2;
            end
            if (acc) mfifo.push_back(byte_in);
            exp_ready = (mfifo.size() < DEPTH);
        end
    end

    // ---------------- monitor for instance A ----------------
    bit     in_frame = 1'b0;
    frame_t cur;
    int     off, idx;
    logic   es, ea, ed;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            check("rst_serial", 32'(serial), 32'd1);
            check("rst_active", 32'(active), 32'd0);
            check("rst_done",   32'(done),   32'd0);
            check("rst_ready",  32'(ready),  32'd1);
        end else begin
            if (!in_frame && expq.size() > 0 && expq[0].start == cyc) begin
                cur      = expq.pop_front();
                in_frame = 1'b1;
            end
            es = 1'b1; ea = 1'b0; ed = 1'b0;
            if (in_frame) begin
                off = cyc - cur.start;
                if (off < FRAME) begin
                    idx = off / N;
                    ea  = 1'b1;
                    if (idx == 0)      es = 1'b0;
                    else if (idx == 9) es = 1'b1;
                    else               es = cur.b[3'(idx - 1)];
                end else begin
                    ed = (off == FRAME);
                    if (off == FRAME + 1) in_frame = 1'b0;
                end
            end
            check("serial", 32'(serial), 32'(es));
            check("active", 32'(active), 32'(ea));
            check("done",   32'(done),   32'(ed));
            check("ready",  32'(ready),  32'(exp_ready));
        end
    end

    // ---------------- receiver model for instance B ----------------
    logic [7:0] bq[$];
    logic [7:0] b_shift;
    logic [7:0] b_exp;
    bit         b_busy = 1'b0;
    int         b_start, bo, bidx;
    int         rx_cnt_b = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (!b_busy) begin
                if (serial_b === 1'b0) begin
                    b_busy  = 1'b1;
                    b_start = cyc;
                end
            end else begin
                bo = cyc - b_start;
                if ((bo % NB) == NB / 2 && bo / NB <= 9) begin
                    bidx = bo / NB;
                    if (bidx == 0)      check("b_start_bit", 32'(serial_b), 32'd0);
                    else if (bidx == 9) check("b_stop_bit",  32'(serial_b), 32'd1);
                    else                b_shift[3'(bidx - 1)] = serial_b;
                end
                if (bo == 10 * NB - 1) check("b_done_early", 32'(done_b), 32'd0);
                if (bo == 10 * NB) begin
                    check("b_done_len", 32'(done_b), 32'd1);
                    b_exp = (bq.size() > 0) ? bq.pop_front() : 8'hxx;
                    check("b_rx_byte", 32'(b_shift), 32'(b_exp));
                    rx_cnt_b++;
                    b_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [7:0] b);
        @(negedge clk); #1;
        dv = 1'b1;
        byte_in = b;
    endtask

    task automatic release_dv();
        @(negedge clk); #1;
        dv = 1'b0;
        byte_in = 8'($urandom);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] burst [6];

    initial begin
        dv = 1'b0; byte_in = '0; dv_b = 1'b0; byte_b = '0;
        burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55;
        burst[3] = 8'h81; burst[4] = 8'h3C; burst[5] = 8'h77;
        wait_cycles(3); #1 rst_n = 1'b1;

        // Single frame
        drive(8'hA5);
        release_dv();
        wait_cycles(FRAME + 10);

        // Burst into a 4-deep FIFO; the sixth byte finds it full
        for (int i = 0; i < 6; i++) drive(burst[i]);
        release_dv();
        wait_cycles(6 * (FRAME + 2) + 20);

        // Random traffic; i_Tx_Byte wanders while idle to expose capture bugs
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            dv      = ($urandom_range(0, 9) == 0);
            byte_in = 8'($urandom);
        end
        release_dv();
        wait_cycles((DEPTH + 1) * (FRAME + 2) + 20);

        // Reset during data bit 3 of 0xF0 with two bytes queued
        drive(8'hF0);
        drive(8'h11);
        drive(8'h22);
        release_dv();
        wait_cycles(4 * N + 2);
        #1 rst_n = 1'b0;
        #1;
        check("imm_rst_serial", 32'(serial), 32'd1);
        check("imm_rst_active", 32'(active), 32'd0);
        check("imm_rst_ready",  32'(ready),  32'd1);
        check("imm_rst_done",   32'(done),   32'd0);
        wait_cycles(3);
        #1 rst_n = 1'b1;
        wait_cycles(2 * FRAME);

        // Instance B: four bytes at the full 434 clocks per bit
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); #1;
            dv_b   = 1'b1;
            byte_b = 8'($urandom);
            bq.push_back(byte_b);
        end
        @(negedge clk); #1;
        dv_b   = 1'b0;
        byte_b = 8'($urandom);
        for (int i = 0; i < DEPTH * (10 * NB + 2) + 500 && rx_cnt_b < DEPTH; i++) @(negedge clk);

        check("a_drained",  32'(expq.size() + int'(in_frame)), 32'd0);
        check("b_rx_count", 32'(rx_cnt_b), 32'(DEPTH));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
